// File: rtl/hilo_unit.sv
// HI/LO register block: single-cycle MULT/MULTU, 32-step restoring DIV/DIVU,
// MTHI/MTLO writes. Divides stall the pipeline through o_busy and can be flushed.
module hilo_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_hl_op,
  input  logic [31:0] i_rs_in,
  input  logic [31:0] i_rt_in,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_hi_out,
  output logic [31:0] o_lo_out
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    DIV_RUN,
    DIV_FIX
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic [31:0] r_divisor;
  logic        r_quotSign;
  logic        r_remSign;
  logic        r_divZero;
  logic [4:0]  r_count;

  logic        w_isDiv;
  logic        w_isSigned;
  logic        w_lastStep;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [63:0] w_mulA;
  logic [63:0] w_mulB;
  logic [63:0] w_prod;
  logic [32:0] w_shiftRem;
  logic        w_fits;
  logic [31:0] w_diff;

  assign w_isDiv    = (i_hl_op == OP_DIV) || (i_hl_op == OP_DIVU);
  assign w_isSigned = (i_hl_op == OP_DIV);
  assign w_lastStep = (r_count == 5'(DIV_ITERS - 1));

  // Operand magnitudes for the divider; DIVU passes raw values.
  assign w_absA = (w_isSigned && i_rs_in[31]) ? -i_rs_in : i_rs_in;
  assign w_absB = (w_isSigned && i_rt_in[31]) ? -i_rt_in : i_rt_in;

  // One 64x64 multiplier serves both MULT and MULTU via sign/zero extension.
  assign w_mulA = (i_hl_op == OP_MULT) ? {{32{i_rs_in[31]}}, i_rs_in} : {32'd0, i_rs_in};
  assign w_mulB = (i_hl_op == OP_MULT) ? {{32{i_rt_in[31]}}, i_rt_in} : {32'd0, i_rt_in};
  assign w_prod = w_mulA * w_mulB;

  // Restoring step: the 33-bit compare decides, the low 32 bits of the difference suffice.
  assign w_shiftRem = {r_rem, r_quot[31]};
  assign w_fits     = (w_shiftRem >= {1'b0, r_divisor});
  assign w_diff     = w_shiftRem[31:0] - r_divisor;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (!i_flush && w_isDiv) begin
          w_nextState = DIV_RUN;
        end
      end
      DIV_RUN: begin
        if (i_flush) begin
          w_nextState = IDLE;
        end else if (w_lastStep) begin
          w_nextState = DIV_FIX;
        end
      end
      DIV_FIX: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_done     <= 1'b0;
      r_rem      <= 32'd0;
      r_quot     <= 32'd0;
      r_divisor  <= 32'd0;
      r_quotSign <= 1'b0;
      r_remSign  <= 1'b0;
      r_divZero  <= 1'b0;
      r_count    <= 5'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!i_flush) begin
            case (i_hl_op)
              OP_MULT, OP_MULTU: begin
                r_hi   <= w_prod[63:32];
                r_lo   <= w_prod[31:0];
                r_done <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                r_quot     <= w_absA;
                r_divisor  <= w_absB;
                r_rem      <= 32'd0;
                r_count    <= 5'd0;
                r_quotSign <= w_isSigned && (i_rs_in[31] ^ i_rt_in[31]);
                r_remSign  <= w_isSigned && i_rs_in[31];
                r_divZero  <= (i_rt_in == 32'd0);
              end
              OP_MTHI: r_hi <= i_rs_in;
              OP_MTLO: r_lo <= i_rs_in;
              default: begin
              end
            endcase
          end
        end
        DIV_RUN: begin
          if (!i_flush) begin
            r_rem   <= w_fits ? w_diff : w_shiftRem[31:0];
            r_quot  <= {r_quot[30:0], w_fits};
            r_count <= r_count + 5'd1;
          end
        end
        DIV_FIX: begin
          // Divide by zero forces LO to all ones even when the signed fixup would negate it.
          if (!i_flush) begin
            r_lo   <= r_divZero ? 32'hFFFF_FFFF : (r_quotSign ? -r_quot : r_quot);
            r_hi   <= r_remSign ? -r_rem : r_rem;
            r_done <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy   = (r_state != IDLE);
  assign o_done   = r_done;
  assign o_hi_out = r_hi;
  assign o_lo_out = r_lo;

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: stimulus queues expected {HI,LO} per result,
// a negedge monitor pops and compares whenever done pulses.
module tb_hilo_unit;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hlOp;
  logic [31:0] rsIn;
  logic [31:0] rtIn;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hiOut;
  logic [31:0] loOut;

  logic [63:0] expQ[$];
  logic [63:0] monExp;
  int          nCompared = 0;
  int          nMismatch = 0;
  int          cycles;

  hilo_unit #(.DIV_ITERS(32)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_hl_op (hlOp),
    .i_rs_in (rsIn),
    .i_rt_in (rtIn),
    .i_flush (flush),
    .o_busy  (busy),
    .o_done  (done),
    .o_hi_out(hiOut),
    .o_lo_out(loOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one op for exactly one accepting edge, then return to NONE.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    hlOp = op;
    rsIn = a;
    rtIn = b;
    @(posedge clk);
    #1;
    hlOp = OP_NONE;
  endtask

  // Issue a divide and count busy cycles; optional disturbance on a given busy cycle.
  task automatic runDivide(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int injectAt, input int flushAt, input int resetAt,
                           output int nBusy);
    applyStimulus(op, a, b);
    nBusy = 0;
    while (busy === 1'b1 && nBusy < 100) begin
      nBusy++;
      if (nBusy == injectAt) begin
        hlOp = OP_MULT;
        rsIn = 32'd3;
        rtIn = 32'd5;
      end
      if (nBusy == flushAt) flush = 1'b1;
      if (nBusy == resetAt) rst = 1'b1;
      @(posedge clk);
      #1;
      hlOp  = OP_NONE;
      flush = 1'b0;
      rst   = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatch++;
        $display("[TB] FAIL unexpectedDone: got done=1 with hi=%h lo=%h, expected no result pending", hiOut, loOut);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("resultHi", hiOut, monExp[63:32]);
        checkOutput("resultLo", loOut, monExp[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    hlOp  = OP_NONE;
    rsIn  = 32'd0;
    rtIn  = 32'd0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("resetHi", hiOut, 32'd0);
    checkOutput("resetLo", loOut, 32'd0);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetDone", {31'd0, done}, 32'd0);

    expQ.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
    applyStimulus(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    checkOutput("multBusy", {31'd0, busy}, 32'd0);
    expQ.push_back({32'h0000_0002, 32'hFFFF_FFFA});
    applyStimulus(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    checkOutput("multuBusy", {31'd0, busy}, 32'd0);

    expQ.push_back({32'd2, 32'd14});
    runDivide(OP_DIVU, 32'd100, 32'd7, 0, 0, 0, cycles);
    checkOutput("divuBusyCycles", cycles, 32'd33);

    expQ.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    runDivide(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, cycles);
    checkOutput("divNegBusyCycles", cycles, 32'd33);

    expQ.push_back({32'd1, 32'hFFFF_FFFD});
    runDivide(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, cycles);
    checkOutput("divNegDivisorCycles", cycles, 32'd33);

    expQ.push_back({32'd5, 32'hFFFF_FFFF});
    runDivide(OP_DIVU, 32'd5, 32'd0, 0, 0, 0, cycles);
    checkOutput("divuZeroCycles", cycles, 32'd33);

    expQ.push_back({32'hFFFF_FFFB, 32'hFFFF_FFFF});
    runDivide(OP_DIV, 32'hFFFF_FFFB, 32'd0, 0, 0, 0, cycles);
    checkOutput("divZeroCycles", cycles, 32'd33);

    expQ.push_back({32'd0, 32'h8000_0000});
    runDivide(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, cycles);
    checkOutput("divOverflowCycles", cycles, 32'd33);

    applyStimulus(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    checkOutput("mthiHi", hiOut, 32'hDEAD_BEEF);
    checkOutput("mthiLo", loOut, 32'h8000_0000);
    checkOutput("mthiDone", {31'd0, done}, 32'd0);
    applyStimulus(OP_MTLO, 32'h1234_5678, 32'd0);
    checkOutput("mtloHi", hiOut, 32'hDEAD_BEEF);
    checkOutput("mtloLo", loOut, 32'h1234_5678);

    expQ.push_back({32'd1, 32'd2});
    runDivide(OP_DIV, 32'd9, 32'd4, 10, 0, 0, cycles);
    checkOutput("divIgnoreOpCycles", cycles, 32'd33);

    expQ.push_back({32'd0, 32'd42});
    expQ.push_back({32'd2, 32'd0});
    hlOp = OP_MULT;
    rsIn = 32'd7;
    rtIn = 32'd6;
    @(posedge clk);
    #1;
    hlOp = OP_MULTU;
    rsIn = 32'h8000_0000;
    rtIn = 32'd4;
    @(posedge clk);
    #1;
    hlOp = OP_NONE;

    flush = 1'b1;
    applyStimulus(OP_MULT, 32'd5, 32'd5);
    flush = 1'b0;
    checkOutput("idleFlushHi", hiOut, 32'd2);
    checkOutput("idleFlushLo", loOut, 32'd0);
    checkOutput("idleFlushDone", {31'd0, done}, 32'd0);

    applyStimulus(OP_MTHI, 32'hAAAA_5555, 32'd0);
    applyStimulus(OP_MTLO, 32'hAAAA_5555, 32'd0);
    runDivide(OP_DIVU, 32'd100, 32'd7, 0, 10, 0, cycles);
    checkOutput("flushBusyCycles", cycles, 32'd10);
    checkOutput("flushHi", hiOut, 32'hAAAA_5555);
    checkOutput("flushLo", loOut, 32'hAAAA_5555);
    checkOutput("flushDone", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("flushDoneLater", {31'd0, done}, 32'd0);

    runDivide(OP_DIVU, 32'd100, 32'd7, 0, 0, 20, cycles);
    checkOutput("resetBusyCycles", cycles, 32'd20);
    checkOutput("midResetHi", hiOut, 32'd0);
    checkOutput("midResetLo", loOut, 32'd0);
    checkOutput("midResetDone", {31'd0, done}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("pendingResults", expQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Multiply/divide and HI/LO register block in the execute stage of the MIPS core, directly upstream of the writeback mux.
- Executes MULT/MULTU in a single cycle and DIV/DIVU iteratively, with a busy signal that stalls the pipeline.
- Handles MTHI/MTLO writes.
- hi_out/lo_out feed the writeback mux's HI and LO inputs, selected by rf_wsel codes 3'b100 and 3'b101, which serve MFHI and MFLO.

Parameters:
DIV_ITERS, 32, restoring-division iteration count; must equal data width (32); fixed, present for documentation/lint only.

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
hl_op  input  3  operation: 000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NONE)
rs_in  input  32  operand A: multiplicand/dividend/MTHI-MTLO source
rt_in  input  32  operand B: multiplier/divisor
flush  input  1  exception/pipeline flush; cancels an in-flight divide
busy  output  1  divide in progress; pipeline must hold the issuing instruction and not present new ops
done  output  1  one-cycle pulse, the cycle after HI/LO were updated by a MULT/MULTU/DIV/DIVU
hi_out  output  32  current HI register
lo_out  output  32  current LO register

Behaviour:
- Reset (rst=1 at an edge):
  - HI=0, LO=0, busy=0, done=0, FSM=IDLE.
  - Reset mid-divide aborts the divide; HI/LO still clear to 0.
- FSM states: IDLE, DIV_RUN, DIV_FIX.
- hl_op is sampled only in IDLE. While busy=1, hl_op is ignored entirely.
- MULT/MULTU (IDLE):
  - At the accepting edge, {HI,LO} <= 64-bit product.
  - MULT treats both operands as signed two's complement; MULTU as unsigned.
  - busy stays 0. done=1 for the following cycle.
- MTHI/MTLO (IDLE):
  - At the edge, HI<=rs_in or LO<=rs_in respectively; the other register is unchanged.
  - done stays 0.
- DIV/DIVU accept (IDLE, edge E0):
  - Latch |dividend| and |divisor| (raw values for DIVU), plus quotient sign (sign A xor sign B) and remainder sign (sign A); DIVU signs = 0.
  - Clear the 32-bit partial remainder and iteration counter; go to DIV_RUN. busy=1 from the cycle after E0.
- DIV_RUN, edges E1..E32:
  - Each edge does one restoring step: shift {rem,quot} left 1; trial-subtract divisor (33-bit compare); keep the difference and set the quotient LSB if non-negative.
  - After the 32nd step, go to DIV_FIX.
- DIV_FIX, edge E33:
  - Apply signs: LO <= quot_sign ? -quot : quot; HI <= rem_sign ? -rem : rem.
  - Go to IDLE. busy=0 and done=1 in the cycle after E33.
  - Total busy = 33 cycles. Result is readable on hi_out/lo_out in the same cycle done=1.
- Divide by zero (no trap):
  - DIVU: LO=32'hFFFFFFFF, HI=rs_in.
  - DIV: LO=32'hFFFFFFFF, HI=rs_in.
  - Latency is unchanged at 33 cycles.
- Signed overflow: DIV 32'h80000000 / 32'hFFFFFFFF gives LO=32'h80000000, HI=0. No special case is needed; the magnitude path yields this.
- Rounding: quotient truncates toward zero; remainder takes the dividend's sign.
- flush:
  - In DIV_RUN or DIV_FIX, flush at an edge returns the FSM to IDLE. HI/LO are unchanged, busy=0 next cycle, and no done pulse.
  - flush in IDLE with a valid hl_op: the op is discarded (flush wins), HI/LO unchanged.
  - flush and rst together: rst wins.
- done is never asserted for two consecutive cycles from one op. Back-to-back MULTs give done on consecutive cycles, one per op.
- hi_out/lo_out are direct register outputs, with no combinational path from the inputs.

Test Plan:
- rst=1 for 2 cycles, then release -> hi_out=0, lo_out=0, busy=0, done=0.
- MULT rs=32'hFFFFFFFE, rt=3 -> next cycle HI=32'hFFFFFFFF, LO=32'hFFFFFFFA, done=1, busy never 1. MULTU same operands -> HI=32'h00000002, LO=32'hFFFFFFFA.
- DIVU rs=100, rt=7 -> busy=1 for exactly 33 cycles, then LO=14, HI=2, done=1 for one cycle. DIV rs=-7 (32'hFFFFFFF9), rt=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- Edge divides:
  - DIVU 5/0 -> LO=32'hFFFFFFFF, HI=5.
  - DIV 32'h80000000/32'hFFFFFFFF -> LO=32'h80000000, HI=0.
  - Both take 33 busy cycles.
- MTHI 32'hDEADBEEF then MTLO 32'h12345678, then start DIV 9/4 and drive MULT on hl_op during cycle 10 of busy:
  - The MULT is ignored.
  - Final result LO=2, HI=1.
- Start DIVU 100/7 with HI/LO preloaded to 32'hAAAA5555 (both registers):
  - Assert flush at busy cycle 10 -> busy=0 next cycle, no done, HI/LO still 32'hAAAA5555.
  - Repeat the run, asserting rst at busy cycle 20 instead -> HI=LO=0.
